// File: rtl/npc_pkg.sv
// Shared LSU types: FSM state encoding, load-type codes and an alignment helper.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] MR_B  = 3'd0;
  localparam logic [2:0] MR_H  = 3'd1;
  localparam logic [2:0] MR_W  = 3'd2;
  localparam logic [2:0] MR_BU = 3'd3;
  localparam logic [2:0] MR_HU = 3'd4;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] mrtype, input logic [1:0] addr_lo);
    logic w_mis;
    w_mis = 1'b0;
    if ((mrtype == MR_H) || (mrtype == MR_HU)) w_mis = addr_lo[0];
    else if (mrtype == MR_W)                  w_mis = (addr_lo != 2'b00);
    return w_mis;
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Combinational load aligner: shift the read word down to the addressed byte, then extend.
module lsu_ext
  import npc_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_mrtype,
  output logic [31:0] o_mdata_c
);

  logic [31:0] w_shift;

  // Shift by whole bytes, then pick width and sign treatment.
  always_comb begin
    w_shift   = i_rdata >> {i_addr_lo, 3'b000};
    o_mdata_c = 32'd0;
    case (i_mrtype)
      MR_B:    o_mdata_c = {{24{w_shift[7]}}, w_shift[7:0]};
      MR_H:    o_mdata_c = {{16{w_shift[15]}}, w_shift[15:0]};
      MR_W:    o_mdata_c = w_shift;
      MR_BU:   o_mdata_c = {24'd0, w_shift[7:0]};
      MR_HU:   o_mdata_c = {16'd0, w_shift[15:0]};
      default: o_mdata_c = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory access per accepted transfer, result held until taken.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (adds misalign output, skips misaligned accesses).
module lsu
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  mvalid,
  input  logic                  mwen,
  input  logic [7:0]            mwmask,
  input  logic [2:0]            mrtype,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] mdata,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_wen,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [7:0]            req_wmask,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_rdata
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                  misalign
`endif
);

  lsu_state_t            r_state;
  lsu_state_t            w_next;
  logic                  r_s_ready;
  logic                  r_m_valid;
  logic                  r_req_valid;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_wmask;
  logic [2:0]            r_mrtype;
  logic [DATA_WIDTH-1:0] r_mdata;
  logic [DATA_WIDTH-1:0] w_ext_data;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_misalign;

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_misalign;
  assign w_misalign = mvalid & is_misaligned(mrtype, addr[1:0]);
  assign misalign   = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept  = (r_state == IDLE) & s_valid;
  assign w_capture = ((r_state == REQ) & req_ready & resp_valid) |
                     ((r_state == WAIT) & resp_valid);

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign req_valid = r_req_valid;
  assign req_wen   = r_wen;
  assign req_addr  = r_addr;
  assign req_wdata = r_wdata;
  assign req_wmask = r_wmask;
  assign mdata     = r_mdata;

  lsu_ext u_ext (
    .i_rdata   (resp_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_mrtype  (r_mrtype),
    .o_mdata_c (w_ext_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; responses outside REQ/WAIT never move the FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (s_valid) w_next = (mvalid && !w_misalign) ? REQ : DONE;
      REQ:     if (req_ready) w_next = resp_valid ? DONE : WAIT;
      WAIT:    if (resp_valid) w_next = DONE;
      DONE:    if (m_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs registered from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_req_valid <= 1'b0;
    end else begin
      r_s_ready   <= (w_next == IDLE);
      r_m_valid   <= (w_next == DONE);
      r_req_valid <= (w_next == REQ);
    end
  end

  // Request fields latched on accept; load result captured with the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wmask  <= 8'd0;
      r_mrtype <= 3'd0;
      r_mdata  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else if (w_accept) begin
      r_wen    <= mwen & mvalid;
      r_addr   <= addr;
      r_wdata  <= wdata;
      r_wmask  <= mwmask;
      r_mrtype <= mrtype;
      r_mdata  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_misalign <= w_misalign;
`endif
    end else if (w_capture && !r_wen) begin
      r_mdata <= w_ext_data;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a per-transaction reference model.
module tb_lsu;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic        mvalid, mwen;
  logic [7:0]  mwmask;
  logic [2:0]  mrtype;
  logic [31:0] addr, wdata, mdata;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready),
    .mvalid(mvalid), .mwen(mwen), .mwmask(mwmask), .mrtype(mrtype),
    .addr(addr), .wdata(wdata), .mdata(mdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
`ifdef LSU_MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load result: byte offset selects the field, type picks width and sign.
  function automatic logic [31:0] ext_model(input logic [2:0] rt, input logic [1:0] lo,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] v;
    sh = rd >> (int'(lo) * 8);
    case (rt)
      3'd0: begin v = sh % 256;   return (v >= 128)   ? v - 32'd256   : v; end
      3'd1: begin v = sh % 65536; return (v >= 32768) ? v - 32'd65536 : v; end
      3'd2: return sh;
      3'd3: return sh % 256;
      3'd4: return sh % 65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit mis_model(input logic [2:0] rt, input logic [31:0] a);
    if (rt == 3'd1 || rt == 3'd4) return (a % 2) != 0;
    if (rt == 3'd2)               return (a % 4) != 0;
    return 1'b0;
  endfunction

  // One complete transfer with chosen memory-side and write-back delays.
  task automatic run_txn(input bit mv, input bit we, input logic [7:0] mask, input logic [2:0] rt,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int req_dly, input int resp_dly, input int bp_dly);
    bit          mis, skip;
    logic [31:0] exp_md;
    mis    = mv && MIS_EN && mis_model(rt, a);
    skip   = !mv || mis;
    exp_md = (skip || we) ? 32'd0 : ext_model(rt, a[1:0], rd);

    @(negedge clk);
    chk("s_ready_idle", 32'(s_ready), 32'd1);
    s_valid = 1'b1; mvalid = mv; mwen = we; mwmask = mask; mrtype = rt; addr = a; wdata = wd;
    @(negedge clk);
    s_valid = 1'b0; mvalid = 1'($urandom); mwen = 1'($urandom); mwmask = 8'($urandom);
    mrtype = 3'($urandom); addr = $urandom; wdata = $urandom;
    chk("s_ready_busy", 32'(s_ready), 32'd0);

    if (skip) begin
      chk("req_valid_skip", 32'(req_valid), 32'd0);
    end else begin
      chk("req_valid", 32'(req_valid), 32'd1);
      chk("req_addr", req_addr, a);
      chk("req_wdata", req_wdata, wd);
      chk("req_wmask", 32'(req_wmask), 32'(mask));
      chk("req_wen", 32'(req_wen), 32'(we));
      for (int i = 0; i < req_dly; i++) begin
        @(negedge clk);
        chk("req_hold_valid", 32'(req_valid), 32'd1);
        chk("req_hold_addr", req_addr, a);
        chk("req_hold_wdata", req_wdata, wd);
        chk("req_hold_mask", 32'({req_wen, req_wmask}), 32'({we, mask}));
      end
      req_ready  = 1'b1;
      resp_valid = (resp_dly == 0);
      resp_rdata = (resp_dly == 0) ? rd : $urandom;
      @(negedge clk);
      req_ready = 1'b0; resp_valid = 1'b0;
      if (resp_dly > 0) begin
        for (int i = 0; i < resp_dly - 1; i++) begin
          chk("wait_no_req", 32'(req_valid), 32'd0);
          chk("wait_no_mvalid", 32'(m_valid), 32'd0);
          @(negedge clk);
        end
        resp_valid = 1'b1; resp_rdata = rd;
        @(negedge clk);
        resp_valid = 1'b0;
      end
    end

    chk("m_valid", 32'(m_valid), 32'd1);
    chk("mdata", mdata, exp_md);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("misalign", 32'(misalign), 32'(mis));
`endif
    for (int i = 0; i < bp_dly; i++) begin
      resp_valid = 1'($urandom); resp_rdata = $urandom;
      @(negedge clk);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_mdata", mdata, exp_md);
    end
    resp_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_drop", 32'(m_valid), 32'd0);
    chk("s_ready_back", 32'(s_ready), 32'd1);
    if ($urandom % 2 == 1) begin
      resp_valid = 1'b1; resp_rdata = $urandom;
      @(negedge clk);
      resp_valid = 1'b0;
      chk("idle_resp_ignored", 32'(m_valid), 32'd0);
    end
  endtask

  // Reset while a load sits in WAIT; the late response must be dropped.
  task automatic reset_mid_wait();
    @(negedge clk);
    s_valid = 1'b1; mvalid = 1'b1; mwen = 1'b0; mwmask = 8'hFF; mrtype = 3'd2;
    addr = 32'h8000_0010; wdata = 32'h1111_2222;
    @(negedge clk);
    s_valid = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("rst_pre_wait", 32'({req_valid, m_valid}), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_s_ready", 32'(s_ready), 32'd1);
    chk("rst_async_addr", req_addr, 32'd0);
    chk("rst_async_wdata", req_wdata, 32'd0);
    chk("rst_async_ctl", 32'({req_valid, req_wen, m_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_late_resp", 32'(m_valid), 32'd0);
      @(negedge clk);
    end
    chk("rst_idle", 32'(s_ready), 32'd1);
    chk("rst_mdata", mdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; mvalid = 1'b0; mwen = 1'b0;
    mwmask = 8'd0; mrtype = 3'd0; addr = 32'd0; wdata = 32'd0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'd0;
    #12;
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    chk("reset_ctl", 32'({m_valid, req_valid, req_wen}), 32'd0);
    chk("reset_mdata", mdata, 32'd0);
    chk("reset_addr", req_addr, 32'd0);
    chk("reset_wfields", 32'(req_wmask) ^ req_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(1'b0, 1'b0, 8'h00, 3'd0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
    run_txn(1'b1, 1'b0, 8'h00, 3'd0, 32'h8000_0003, 32'd0, 32'h80FF_1234, 0, 3, 0);
    run_txn(1'b1, 1'b0, 8'h00, 3'd4, 32'h8000_0002, 32'd0, 32'hBEEF_0000, 1, 1, 0);
    run_txn(1'b1, 1'b1, 8'h0F, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 2, 1, 0);
    run_txn(1'b1, 1'b0, 8'h00, 3'd1, 32'h8000_0002, 32'd0, 32'h8001_7FFF, 0, 0, 4);
    reset_mid_wait();
    run_txn(1'b1, 1'b0, 8'h00, 3'd2, 32'h8000_0002, 32'd0, 32'hA5A5_5A5A, 0, 1, 1);

    for (int t = 0; t < 40; t++) begin
      run_txn(($urandom % 4) != 0, ($urandom % 3) == 0, 8'($urandom), 3'($urandom_range(0, 7)),
              32'h8000_0000 | ($urandom % 256), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of memory requests.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports s_valid input 1 and s_ready output 1: upstream (memory-stage bus) handshake.
REQ-006 SHALL have ports m_valid output 1 and m_ready input 1: downstream (write-back bus) handshake.
REQ-007 SHALL have inputs mvalid 1 (access needed), mwen 1 (store), mwmask 8 (byte mask), mrtype 3 (load type), addr ADDR_WIDTH, wdata 32.
REQ-008 SHALL have output mdata 32: extended load result, held stable while m_valid=1.
REQ-009 SHALL have memory request ports req_valid out 1, req_ready in 1, req_wen out 1, req_addr out ADDR_WIDTH, req_wdata out 32, req_wmask out 8.
REQ-010 SHALL have memory response ports resp_valid in 1 and resp_rdata in 32.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-012 SHALL assert s_ready only in IDLE; a transfer is accepted on s_valid&s_ready and its inputs are registered.
REQ-013 On accept with mvalid=0: IDLE->DONE, mdata=0, m_valid next cycle (latency 1), no memory request.
REQ-014 On accept with mvalid=1: IDLE->REQ; req_valid=1 with registered addr/wdata/wmask/mwen held constant until req_ready.
REQ-015 In REQ: req_valid&req_ready&~resp_valid -> WAIT; req_ready&resp_valid in the same cycle -> DONE, capturing resp_rdata.
REQ-016 In WAIT: resp_valid -> DONE, capturing resp_rdata; otherwise remain in WAIT indefinitely.
REQ-017 Load data SHALL be shifted right by 8*addr[1:0] and then extended: mrtype 0 sign byte, 1 sign half, 2 word, 3 zero byte, 4 zero half, else 0.
REQ-018 Stores (mwen=1) SHALL also wait for resp_valid; mdata=0 for stores.
REQ-019 In DONE: m_valid=1; m_ready -> IDLE; the pipeline does not permit acceptance in the same cycle, so the earliest next accept is one cycle later.
REQ-020 resp_valid received in IDLE or DONE SHALL be ignored.

Reset
REQ-021 On rst: state=IDLE, s_ready=1, m_valid=0, req_valid=0, req_wen=0, mdata=0, all registered request fields=0, asynchronously.
REQ-022 Reset mid-transaction SHALL abandon the access; a late resp_valid after reset SHALL be ignored per REQ-020.

Configuration
REQ-023 Macro LSU_MISALIGN_CHECK_EN: when defined, SHALL add output misalign 1. On an mvalid=1 accept, misalign is set if a half access has addr[0]=1 or a word access has addr[1:0]!=0. A misaligned access SHALL skip memory (IDLE->DONE, mdata=0). misalign is held with m_valid.
REQ-024 Without LSU_MISALIGN_CHECK_EN: no misalign port; all accesses are issued unchanged.

Structure
REQ-025 Package npc_pkg SHALL hold the lsu_state_t enum and the mrtype constants (MR_B, MR_H, MR_W, MR_BU, MR_HU).
REQ-026 Load shift/extension SHALL be a combinational sub-module lsu_ext (rdata, addr[1:0], mrtype -> mdata).

Verification
REQ-027 Non-memory op: s_valid=1, mvalid=0 -> m_valid=1 next cycle, mdata=0, req_valid never asserted.
REQ-028 Load byte: addr=0x80000003, mrtype=0, resp_rdata=0x80FF_1234 after 3-cycle delay -> mdata=0xFFFF_FF80.
REQ-029 Load half unsigned: addr=0x80000002, mrtype=4, resp_rdata=0xBEEF_0000 -> mdata=0x0000_BEEF.
REQ-030 Store: addr=0x80000000, wdata=0xDEADBEEF, mwmask=0x0F; req_ready low 2 cycles -> req_* held stable; resp_valid -> m_valid, mdata=0.
REQ-031 Backpressure and reset: m_ready=0 for 4 cycles -> m_valid and mdata held; rst asserted during WAIT -> IDLE; a subsequent resp_valid causes no m_valid.
REQ-032 With LSU_MISALIGN_CHECK_EN: word load at addr=0x80000002 -> misalign=1, no req_valid, m_valid the next cycle.
